arbitro_saldo: RTL and testbench
================================

ARBITRO_SALDO -- requirements
Module: arbitro_saldo

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of terminal requesters.
REQ-002 The block SHALL have parameter BALANCE_INICIAL, default 5000, balance loaded at reset.
REQ-003 The block SHALL have parameter COMISION, default 10, withdrawal fee in currency units.
REQ-004 clk  input  1  clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N_REQ  per-terminal request; held high until that terminal's done.
REQ-007 tipo  input  N_REQ  per-terminal transaction type; 0 = deposit, 1 = withdrawal.
REQ-008 monto  input  32*N_REQ  per-terminal amount; terminal i uses bits [32*i+31:32*i].
REQ-009 gnt  output  N_REQ  one-hot grant to the terminal being served.
REQ-010 done  output  N_REQ  one-cycle completion pulse to the served terminal.
REQ-011 fondos_insuficientes  output  1  valid with done; withdrawal rejected.
REQ-012 balance_out  output  64  balance after the transaction; valid with done.
REQ-013 ocupado  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, CAPTURA, CALCULO and RESPUESTA; each non-IDLE state SHALL last exactly one cycle.
- IDLE->CAPTURA when any req bit is high, else stay in IDLE.
- CAPTURA->CALCULO, CALCULO->RESPUESTA, RESPUESTA->IDLE unconditionally.
REQ-015 In IDLE the block SHALL select the winner round-robin: the first asserted req at or after pointer ptr, searching upward with wrap from N_REQ-1 to 0.
REQ-016 gnt[winner] SHALL be high during CAPTURA, CALCULO and RESPUESTA; gnt SHALL be zero in IDLE.
REQ-017 In CAPTURA the block SHALL latch the winner's tipo and monto; later changes on those inputs SHALL be ignored.
REQ-018 Deposit in CALCULO: balance = balance + monto (zero-extended); on overflow the balance SHALL saturate at 2^64-1.
REQ-019 Withdrawal in CALCULO: cost = monto + fee; if cost <= balance then balance = balance - cost, else the balance SHALL be unchanged and the insufficient flag set.
REQ-020 Withdrawal equal to balance SHALL be accepted and leave balance 0.
REQ-021 monto 0 SHALL complete normally and leave the balance unchanged, except that a withdrawal SHALL still deduct the fee.
REQ-022 In RESPUESTA, done[winner] SHALL pulse for one cycle with fondos_insuficientes and balance_out valid, and ptr SHALL become (winner+1) mod N_REQ.
REQ-023 Deassertion of req[winner] before done SHALL NOT abort the transaction.
REQ-024 A terminal that holds req after its done SHALL be re-arbitrated as a new request in the next IDLE.
REQ-025 Request-to-done latency SHALL be 4 cycles: done is high in the 4th cycle after IDLE samples req.
REQ-026 fondos_insuficientes and balance_out SHALL hold their values until the next done.

Reset
REQ-027 On rst the block SHALL enter IDLE and set balance = BALANCE_INICIAL and ptr = 0.
REQ-028 On rst the outputs SHALL be set to gnt = 0, done = 0, fondos_insuficientes = 0, balance_out = 0 and ocupado = 0.
REQ-029 rst mid-transaction SHALL abort the transaction with no balance update and no done pulse.

Configuration
REQ-030 With macro COMISION_EN defined, the withdrawal fee SHALL be COMISION.
REQ-031 Without COMISION_EN, the withdrawal fee SHALL be 0.

Structure
REQ-032 Package arbitro_pkg SHALL hold the FSM state encoding, the TIPO_DEPOSITO/TIPO_RETIRO constants and the 64-bit all-ones saturation constant.
REQ-033 Winner selection SHALL be in sub-module rr_selector, with inputs req and ptr and outputs a one-hot winner and a valid flag.

Verification (COMISION_EN defined unless noted; "req" values are N_REQ-bit bitmasks)
REQ-034 Deposit: reset, req = 0001, tipo 0, monto 100 -> done[0] at cycle 4, balance_out 5100, fondos_insuficientes 0.
REQ-035 Rejected withdrawal: req = 0010, tipo 1, monto 4995 -> fondos_insuficientes 1, balance_out 5000. Same case without COMISION_EN -> fondos_insuficientes 0, balance_out 5.
REQ-036 Round-robin: req = 1111 held high -> grant order 0,1,2,3,0; each done 4 cycles apart.
REQ-037 Saturation: preload by repeated deposits of 0xFFFFFFFF until the balance saturates -> balance_out 0xFFFFFFFFFFFFFFFF with no wrap.
REQ-038 Reset mid-op: assert rst during CALCULO of a 100 deposit -> no done pulse; the next deposit of 0 returns balance_out 5000.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared FSM encoding, transaction-type constants and helpers for the arbitro_saldo
// balance arbiter.
package arbitro_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAPTURA   = 2'd1,
    CALCULO   = 2'd2,
    RESPUESTA = 2'd3
  } estado_t;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  localparam logic [63:0] SALDO_MAX = {64{1'b1}};

  // Pointer width that stays legal for a single requester.
  function automatic int unsigned ancho_ptr(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_selector.sv
// Round-robin winner search: first asserted req at or after ptr, wrapping from
// N_REQ-1 back to 0. Purely combinational.
module rr_selector
  import arbitro_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = ancho_ptr(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  always_comb begin
    int unsigned idx;
    logic        found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/arbitro_saldo.sv
// Shared-balance arbiter: serves one terminal at a time through a 4-state FSM.
// Define COMISION_EN to charge COMISION on every withdrawal (fee is 0 otherwise).
module arbitro_saldo
  import arbitro_pkg::*;
#(
  parameter int unsigned N_REQ           = 4,
  parameter logic [63:0] BALANCE_INICIAL = 64'd5000,
  parameter int unsigned COMISION        = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     tipo,
  input  logic [32*N_REQ-1:0]  monto,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 fondos_insuficientes,
  output logic [63:0]          balance_out,
  output logic                 ocupado
);

  localparam int unsigned PTR_W = ancho_ptr(N_REQ);

`ifdef COMISION_EN
  localparam bit COMISION_ON = 1'b1;
`else
  localparam bit COMISION_ON = 1'b0;
`endif
  localparam logic [63:0] FEE = COMISION_ON ? 64'(COMISION) : 64'd0;

  estado_t          r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_idx;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_tipo;
  logic [31:0]      r_monto;
  logic [63:0]      r_balance;
  logic [63:0]      r_balance_out;
  logic             r_fondos;

  logic [N_REQ-1:0] w_winner;
  logic             w_valid;
  logic [PTR_W-1:0] w_win_idx;
  logic [PTR_W-1:0] w_ptr_next;
  logic [64:0]      w_suma;
  logic [63:0]      w_costo;
  logic [63:0]      w_saldo_nuevo;
  logic             w_rechazo;

  rr_selector #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_selector (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner[i]) w_win_idx = PTR_W'(i);
    end
  end

  assign w_ptr_next = (r_idx == PTR_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

  // Deposits saturate instead of wrapping; rejected withdrawals keep the balance.
  always_comb begin
    w_suma        = {1'b0, r_balance} + {33'd0, r_monto};
    w_costo       = {32'd0, r_monto} + FEE;
    w_saldo_nuevo = r_balance;
    w_rechazo     = 1'b0;
    if (r_tipo == TIPO_DEPOSITO) begin
      w_saldo_nuevo = w_suma[64] ? SALDO_MAX : w_suma[63:0];
    end else if (w_costo <= r_balance) begin
      w_saldo_nuevo = r_balance - w_costo;
    end else begin
      w_rechazo = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_idx         <= '0;
      r_gnt         <= '0;
      r_done        <= '0;
      r_tipo        <= TIPO_DEPOSITO;
      r_monto       <= '0;
      r_balance     <= BALANCE_INICIAL;
      r_balance_out <= '0;
      r_fondos      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gnt   <= w_winner;
            r_idx   <= w_win_idx;
            r_state <= CAPTURA;
          end
        end
        CAPTURA: begin
          r_tipo  <= tipo[r_idx];
          r_monto <= monto[32*r_idx +: 32];
          r_state <= CALCULO;
        end
        CALCULO: begin
          r_balance     <= w_saldo_nuevo;
          r_balance_out <= w_saldo_nuevo;
          r_fondos      <= w_rechazo;
          r_done        <= r_gnt;
          r_state       <= RESPUESTA;
        end
        RESPUESTA: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_ptr   <= w_ptr_next;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt                  = r_gnt;
  assign done                 = r_done;
  assign fondos_insuficientes = r_fondos;
  assign balance_out          = r_balance_out;
  assign ocupado              = (r_state != IDLE);

endmodule

// File: tb/tb_arbitro_saldo.sv
// Self-checking bench for arbitro_saldo: directed scenarios plus randomized traffic
// against a transaction-level model of the shared balance.
module tb_arbitro_saldo;
  import arbitro_pkg::*;

  localparam int N = 4;
  localparam logic [63:0] INI     = 64'd5000;
  localparam int unsigned COM     = 10;
  localparam logic [63:0] INI_SAT = 64'hFFFF_FFFE_FFFF_FFFF;
`ifdef COMISION_EN
  localparam logic [63:0] FEE_M = 64'(COM);
`else
  localparam logic [63:0] FEE_M = 64'd0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     tipo;
  logic [32*N-1:0]  monto;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic             fondos;
  logic [63:0]      bal_out;
  logic             ocupado;

  logic             req_s;
  logic             tipo_s;
  logic [31:0]      monto_s;
  logic             gnt_s;
  logic             done_s;
  logic             fondos_s;
  logic [63:0]      bal_s;
  logic             ocup_s;

  always #5 clk = ~clk;

  arbitro_saldo #(
    .N_REQ           (N),
    .BALANCE_INICIAL (INI),
    .COMISION        (COM)
  ) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .req                  (req),
    .tipo                 (tipo),
    .monto                (monto),
    .gnt                  (gnt),
    .done                 (done),
    .fondos_insuficientes (fondos),
    .balance_out          (bal_out),
    .ocupado              (ocupado)
  );

  // Second instance preloaded near the top of the range to reach saturation quickly.
  arbitro_saldo #(
    .N_REQ           (1),
    .BALANCE_INICIAL (INI_SAT),
    .COMISION        (COM)
  ) u_sat (
    .clk                  (clk),
    .rst                  (rst),
    .req                  (req_s),
    .tipo                 (tipo_s),
    .monto                (monto_s),
    .gnt                  (gnt_s),
    .done                 (done_s),
    .fondos_insuficientes (fondos_s),
    .balance_out          (bal_s),
    .ocupado              (ocup_s)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] m_bal;
  int          m_ptr;
  logic [63:0] s_bal;

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_txn(input int w, input logic t, input logic [31:0] a,
                           output logic f, output logic [63:0] b);
    logic [63:0] amt;
    logic [63:0] cost;
    amt = {32'd0, a};
    f   = 1'b0;
    if (t == TIPO_DEPOSITO) begin
      if (amt > (SALDO_MAX - m_bal)) m_bal = SALDO_MAX;
      else m_bal = m_bal + amt;
    end else begin
      cost = amt + FEE_M;
      if (cost > m_bal) f = 1'b1;
      else m_bal = m_bal - cost;
    end
    b     = m_bal;
    m_ptr = (w + 1) % N;
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    req     = '0;
    tipo    = '0;
    monto   = '0;
    req_s   = 1'b0;
    tipo_s  = 1'b0;
    monto_s = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_bal = INI;
    m_ptr = 0;
    s_bal = INI_SAT;
  endtask

  // Drives one request; lat counts cycles with the IDLE sampling cycle as 1.
  task automatic run_txn(input logic [N-1:0] r, input logic [N-1:0] t,
                         input logic [32*N-1:0] m, input bit drop, input bit scramble,
                         output int lat, output logic [N-1:0] g, output logic [N-1:0] d,
                         output logic f, output logic [63:0] b);
    req   = r;
    tipo  = t;
    monto = m;
    lat   = 1;
    g     = '0;
    d     = '0;
    f     = 1'bx;
    b     = 'x;
    while (lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
      if (gnt != '0 && g == '0) g = gnt;
      if (done != '0) begin
        d = done;
        f = fondos;
        b = bal_out;
        break;
      end
      if (lat == 2 && drop) req = '0;
      if (lat == 3 && scramble) begin
        tipo = N'($urandom);
        for (int i = 0; i < N; i++) monto[32*i +: 32] = $urandom;
      end
    end
    req = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (gnt !== '0) begin n_err++; $display("FAIL reset_gnt: got %b exp 0", gnt); end
    n_checks++; if (done !== '0) begin n_err++; $display("FAIL reset_done: got %b exp 0", done); end
    n_checks++; if (fondos !== 1'b0) begin n_err++; $display("FAIL reset_fondos: got %b exp 0", fondos); end
    n_checks++; if (bal_out !== 64'd0) begin n_err++; $display("FAIL reset_balance_out: got %0d exp 0", bal_out); end
    n_checks++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL reset_ocupado: got %b exp 0", ocupado); end
    @(posedge clk);
    #1;
    n_checks++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL idle_ocupado: got %b exp 0", ocupado); end
  endtask

  task automatic test_deposit();
    int lat; logic [N-1:0] g, d; logic f, ef; logic [63:0] b, eb; int w;
    apply_reset();
    w = pick(4'b0001, m_ptr);
    model_txn(w, TIPO_DEPOSITO, 32'd100, ef, eb);
    run_txn(4'b0001, 4'b0000, {96'd0, 32'd100}, 1'b0, 1'b0, lat, g, d, f, b);
    n_checks++; if (lat !== 4) begin n_err++; $display("FAIL dep_latency: got %0d exp 4", lat); end
    n_checks++; if (g !== 4'b0001) begin n_err++; $display("FAIL dep_gnt: got %b exp 0001", g); end
    n_checks++; if (d !== 4'b0001) begin n_err++; $display("FAIL dep_done: got %b exp 0001", d); end
    n_checks++; if (b !== eb) begin n_err++; $display("FAIL dep_balance: got %0d exp %0d", b, eb); end
    n_checks++; if (b !== 64'd5100) begin n_err++; $display("FAIL dep_5100: got %0d exp 5100", b); end
    n_checks++; if (f !== ef) begin n_err++; $display("FAIL dep_fondos: got %b exp %b", f, ef); end
    n_checks++; if (done !== '0 || gnt !== '0) begin n_err++; $display("FAIL dep_pulse_width: done %b gnt %b exp 0", done, gnt); end
  endtask

  task automatic test_reject_and_hold();
    int lat; logic [N-1:0] g, d; logic f, ef; logic [63:0] b, eb; int w;
    apply_reset();
    w = pick(4'b0010, m_ptr);
    model_txn(w, TIPO_RETIRO, 32'd4995, ef, eb);
    run_txn(4'b0010, 4'b0010, {64'd0, 32'd4995, 32'd0}, 1'b0, 1'b0, lat, g, d, f, b);
    n_checks++; if (d !== 4'b0010) begin n_err++; $display("FAIL rej_done: got %b exp 0010", d); end
    n_checks++; if (f !== ef) begin n_err++; $display("FAIL rej_fondos: got %b exp %b", f, ef); end
    n_checks++; if (b !== eb) begin n_err++; $display("FAIL rej_balance: got %0d exp %0d", b, eb); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (fondos !== ef || bal_out !== eb) begin
      n_err++; $display("FAIL rej_hold: got %b/%0d exp %b/%0d", fondos, bal_out, ef, eb);
    end
  endtask

  task automatic test_exact_and_zero();
    int lat; logic [N-1:0] g, d, mask; logic f, ef; logic [63:0] b, eb; int w;
    logic [31:0] amt;
    logic [32*N-1:0] mv;
    // Withdraw exactly the balance (net of fee) on terminal 2.
    amt  = 32'(m_bal - FEE_M);
    mask = 4'b0100;
    mv   = '0; mv[64 +: 32] = amt;
    w = pick(mask, m_ptr);
    model_txn(w, TIPO_RETIRO, amt, ef, eb);
    run_txn(mask, mask, mv, 1'b0, 1'b0, lat, g, d, f, b);
    n_checks++; if (b !== 64'd0 || b !== eb) begin n_err++; $display("FAIL exact_balance: got %0d exp 0", b); end
    n_checks++; if (f !== 1'b0) begin n_err++; $display("FAIL exact_fondos: got %b exp 0", f); end
    // Deposit 50 on terminal 3, then zero-amount withdrawal and deposit on terminal 0.
    mask = 4'b1000; mv = '0; mv[96 +: 32] = 32'd50;
    w = pick(mask, m_ptr);
    model_txn(w, TIPO_DEPOSITO, 32'd50, ef, eb);
    run_txn(mask, 4'b0000, mv, 1'b0, 1'b0, lat, g, d, f, b);
    n_checks++; if (b !== eb) begin n_err++; $display("FAIL dep50_balance: got %0d exp %0d", b, eb); end
    mask = 4'b0001;
    w = pick(mask, m_ptr);
    model_txn(w, TIPO_RETIRO, 32'd0, ef, eb);
    run_txn(mask, 4'b0001, '0, 1'b0, 1'b0, lat, g, d, f, b);
    n_checks++; if (b !== eb || f !== ef) begin
      n_err++; $display("FAIL zero_withdraw: got %0d/%b exp %0d/%b", b, f, eb, ef);
    end
    w = pick(mask, m_ptr);
    model_txn(w, TIPO_DEPOSITO, 32'd0, ef, eb);
    run_txn(mask, 4'b0000, '0, 1'b0, 1'b0, lat, g, d, f, b);
    n_checks++; if (b !== eb || d !== 4'b0001) begin
      n_err++; $display("FAIL zero_deposit: got %0d done %b exp %0d", b, d, eb);
    end
  endtask

  task automatic test_round_robin();
    logic [32*N-1:0] mv; int cyc, last, n, got, w; logic ef; logic [63:0] eb;
    apply_reset();
    for (int i = 0; i < N; i++) mv[32*i +: 32] = $urandom_range(1, 1000);
    req = '1; tipo = '0; monto = mv;
    cyc = 0; last = 0; n = 0;
    while (n < 5 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done != '0) begin
        got = -1;
        for (int i = 0; i < N; i++) if (done[i]) got = i;
        w = pick('1, m_ptr);
        model_txn(w, TIPO_DEPOSITO, mv[32*w +: 32], ef, eb);
        n_checks++; if (got !== w) begin n_err++; $display("FAIL rr_order: got %0d exp %0d", got, w); end
        n_checks++; if (bal_out !== eb) begin n_err++; $display("FAIL rr_balance: got %0d exp %0d", bal_out, eb); end
        if (n == 0) begin
          n_checks++; if (cyc !== 3) begin n_err++; $display("FAIL rr_first_latency: got %0d exp 3 edges", cyc); end
        end else begin
          n_checks++; if (cyc - last !== 4) begin n_err++; $display("FAIL rr_spacing: got %0d exp 4", cyc - last); end
        end
        last = cyc;
        n++;
      end
    end
    n_checks++; if (n !== 5) begin n_err++; $display("FAIL rr_timeout: got %0d dones exp 5", n); end
    req = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [N-1:0] g, d; logic f, ef; logic [63:0] b, eb; int w; bit seen;
    apply_reset();
    req = 4'b0001; tipo = '0; monto = {96'd0, 32'd100};
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (ocupado !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b exp 1", ocupado); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (done !== '0 || gnt !== '0 || ocupado !== 1'b0) begin
      n_err++; $display("FAIL mid_abort: done %b gnt %b ocupado %b exp 0", done, gnt, ocupado);
    end
    rst = 1'b0; req = '0;
    m_bal = INI; m_ptr = 0; s_bal = INI_SAT;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done != '0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_done: got %b exp 0", seen); end
    w = pick(4'b0001, m_ptr);
    model_txn(w, TIPO_DEPOSITO, 32'd0, ef, eb);
    run_txn(4'b0001, 4'b0000, '0, 1'b0, 1'b0, lat, g, d, f, b);
    n_checks++; if (b !== eb || b !== 64'd5000) begin n_err++; $display("FAIL mid_balance: got %0d exp 5000", b); end
  endtask

  task automatic test_random();
    int lat, w; logic [N-1:0] r, t, g, d, oh; logic [32*N-1:0] mv;
    logic f, ef; logic [63:0] b, eb; bit drop, scr;
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      t = N'($urandom);
      for (int i = 0; i < N; i++) begin
        mv[32*i +: 32] = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 4000);
      end
      drop = 1'($urandom);
      scr  = 1'($urandom);
      w = pick(r, m_ptr);
      oh = '0; oh[w] = 1'b1;
      model_txn(w, t[w], mv[32*w +: 32], ef, eb);
      run_txn(r, t, mv, drop, scr, lat, g, d, f, b);
      n_checks++; if (lat !== 4 || g !== oh || d !== oh) begin
        n_err++; $display("FAIL rnd_grant[%0d]: lat %0d gnt %b done %b exp 4 %b", k, lat, g, d, oh);
      end
      n_checks++; if (b !== eb || f !== ef) begin
        n_err++; $display("FAIL rnd_result[%0d]: got %0d/%b exp %0d/%b", k, b, f, eb, ef);
      end
    end
  endtask

  task automatic test_saturation();
    bit got;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      req_s = 1'b1; tipo_s = TIPO_DEPOSITO; monto_s = 32'hFFFF_FFFF;
      got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        @(posedge clk); #1;
        if (done_s) got = 1'b1;
      end
      if (64'hFFFF_FFFF > (SALDO_MAX - s_bal)) s_bal = SALDO_MAX;
      else s_bal = s_bal + 64'hFFFF_FFFF;
      n_checks++; if (!got) begin n_err++; $display("FAIL sat_timeout[%0d]: no done", k); end
      n_checks++; if (bal_s !== s_bal || fondos_s !== 1'b0) begin
        n_err++; $display("FAIL sat_balance[%0d]: got %h exp %h", k, bal_s, s_bal);
      end
      req_s = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++; if (bal_s !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL sat_final: got %h exp ffffffffffffffff", bal_s);
    end
  endtask

  initial begin
    test_reset();
    test_deposit();
    test_reject_and_hold();
    test_exact_and_zero();
    test_round_robin();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
